// File: rtl/ibuf_pkg.sv
// Shared types and constants for the systolic-array input buffer.
package ibuf_pkg;

    localparam int IBUF_DEPTH = 256;
    localparam int IBUF_AW    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ibuf_state_e;

endpackage

// File: rtl/ibuf_1r1w.sv
// 256-entry single-write / single-read bank with registered read data; no reset on storage.
module ibuf_1r1w
    import ibuf_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [IBUF_AW-1:0] waddr_i,
    input  logic [DW-1:0]      wdata_i,
    input  logic               re_i,
    input  logic [IBUF_AW-1:0] raddr_i,
    output logic [DW-1:0]      rdata_o
);

    logic [DW-1:0] mem_q [IBUF_DEPTH];
    logic [DW-1:0] rdata_q;

    // Same-address write and read in one cycle returns the previous contents.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ibuf.sv
// Row input buffer: ping-pong banks streamed through a SKEW-deep pipe into the array row.
module ibuf
    import ibuf_pkg::*;
#(
    parameter int SKEW = 0,
    parameter int DW   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [8:0]    ibus_wadr,
    input  logic [DW-1:0] ibus_wdata,
    input  logic          ibus_wen,
    input  logic [7:0]    run_cntr,
    input  logic          bank_sel,
    input  logic          start,
    input  logic          adv,
    output logic [DW-1:0] i_data,
    output logic          i_valid,
    output logic          i_running,
    output logic          finish
);

    ibuf_state_e        state_q;
    logic [IBUF_AW-1:0] raddr_q;
    logic [7:0]         cnt_q;
    logic               bank_q;
    logic               v0_q;
    logic               l0_q;
    logic               zfin_q;

    logic               re;
    logic [DW-1:0]      rdata0, rdata1;
    logic [SKEW:0]          vld;
    logic [SKEW:0]          lst;
    logic [SKEW:0][DW-1:0]  dat;

    assign re = adv && (state_q == RUN);

    ibuf_1r1w #(.DW(DW)) u_bank0 (
        .clk_i   (clk),
        .we_i    (ibus_wen && !ibus_wadr[8]),
        .waddr_i (ibus_wadr[7:0]),
        .wdata_i (ibus_wdata),
        .re_i    (re && !bank_q),
        .raddr_i (raddr_q),
        .rdata_o (rdata0)
    );

    ibuf_1r1w #(.DW(DW)) u_bank1 (
        .clk_i   (clk),
        .we_i    (ibus_wen && ibus_wadr[8]),
        .waddr_i (ibus_wadr[7:0]),
        .wdata_i (ibus_wdata),
        .re_i    (re && bank_q),
        .raddr_i (raddr_q),
        .rdata_o (rdata1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            raddr_q <= '0;
            cnt_q   <= '0;
            bank_q  <= 1'b0;
            v0_q    <= 1'b0;
            l0_q    <= 1'b0;
            zfin_q  <= 1'b0;
        end else begin
            zfin_q <= 1'b0;
            if (start) begin
                // A start in any state restarts; in-flight words are dropped.
                v0_q    <= 1'b0;
                l0_q    <= 1'b0;
                raddr_q <= '0;
                cnt_q   <= run_cntr;
                bank_q  <= bank_sel;
                if (run_cntr != 8'd0) begin
                    state_q <= RUN;
                end else begin
                    state_q <= IDLE;
                    zfin_q  <= 1'b1;
                end
            end else if (adv) begin
                case (state_q)
                    RUN: begin
                        v0_q    <= 1'b1;
                        l0_q    <= (cnt_q == 8'd1);
                        raddr_q <= raddr_q + 8'd1;
                        cnt_q   <= cnt_q - 8'd1;
                        if (cnt_q == 8'd1) state_q <= DRAIN;
                    end
                    DRAIN: begin
                        v0_q <= 1'b0;
                        l0_q <= 1'b0;
                        if (vld[SKEW] && lst[SKEW]) state_q <= IDLE;
                    end
                    default: begin
                        v0_q <= 1'b0;
                        l0_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign vld[0] = v0_q;
    assign lst[0] = l0_q;
    assign dat[0] = bank_q ? rdata1 : rdata0;

    for (genvar s = 1; s <= SKEW; s++) begin : g_skew
        logic          v_q;
        logic          l_q;
        logic [DW-1:0] d_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                l_q <= 1'b0;
                d_q <= '0;
            end else if (start) begin
                v_q <= 1'b0;
            end else if (adv) begin
                v_q <= vld[s-1];
                l_q <= lst[s-1];
                d_q <= dat[s-1];
            end
        end

        assign vld[s] = v_q;
        assign lst[s] = l_q;
        assign dat[s] = d_q;
    end

    // Stage 0 is the unreset RAM register, so data is gated by its valid bit.
    assign i_data    = vld[SKEW] ? dat[SKEW] : '0;
    assign i_valid   = vld[SKEW] && adv;
    assign finish    = (vld[SKEW] && lst[SKEW] && adv) || zfin_q;
    assign i_running = (state_q != IDLE);

endmodule
